// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: operation codes, FSM states
// and default widths.
package product_accumulator_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result FIFO; in_ready is registered from the next occupancy so it
// never depends combinationally on out_ready.
module result_fifo2 #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_n;
  logic         ready_q;
  logic         do_push;
  logic         pop;

  assign do_push   = push && ready_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_q;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_n = count;
    if (do_push && !pop)
      count_n = count + 2'd1;
    else if (!do_push && pop)
      count_n = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // ready_q stays low through reset and rises on the first edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      count   <= count_n;
      ready_q <= (count_n != 2'd2);
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Saturating unsigned accumulator of multiplier products with a term counter;
// closed accumulations are queued in a two-entry result FIFO.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_product,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam int RES_W = ACC_W + 1 + CNT_W;

  state_e             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n, acc_cur, ext;
  logic [ACC_W:0]     sum;
  logic               ovf, ovf_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic               accept;
  logic               push;
  logic [RES_W-1:0]   push_data;
  logic [RES_W-1:0]   pop_data;

  assign accept  = in_valid && in_ready;
  assign ext     = ACC_W'(in_product);
  assign acc_cur = (state == IDLE) ? '0 : acc;
  assign sum     = {1'b0, acc_cur} + {1'b0, ext};
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    ovf_n     = ovf;
    cnt_n     = cnt;
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      case (in_op)
        OP_LOAD: begin
          acc_n   = ext;
          ovf_n   = 1'b0;
          cnt_n   = CNT_W'(1);
          state_n = ACCUM;
        end
        OP_ADD: begin
          acc_n   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
          ovf_n   = ovf | sum[ACC_W];
          cnt_n   = cnt_inc;
          state_n = ACCUM;
        end
        OP_SUB: begin
          if (ext > acc_cur) begin
            acc_n = '0;
            ovf_n = 1'b1;
          end else begin
            acc_n = acc_cur - ext;
          end
          cnt_n   = cnt_inc;
          state_n = ACCUM;
        end
        default: begin
          acc_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
      // Emission captures the post-operation result, then the accumulator restarts.
      if (in_last) begin
        push      = 1'b1;
        push_data = {acc_n, ovf_n, cnt_n};
        acc_n     = '0;
        ovf_n     = 1'b0;
        cnt_n     = '0;
        state_n   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      acc <= acc_n;
      ovf <= ovf_n;
      cnt <= cnt_n;
    end
  end

  result_fifo2 #(
    .W(RES_W)
  ) u_result_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (pop_data)
  );

  assign {out_acc, out_ovf, out_count} = pop_data;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: scenario tasks push expected
// results, a negedge monitor pops and compares them on each handshake.
module tb_product_accumulator;

  typedef struct packed {
    logic [39:0] acc;
    logic        ovf;
    logic [7:0]  cnt;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_product;
  logic [1:0]  in_op;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_acc;
  logic        out_ovf;
  logic [7:0]  out_count;

  res_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [39:0] m_acc;
  logic        m_ovf;
  logic [7:0]  m_cnt;

  product_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_op      (in_op),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_ovf    (out_ovf),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 unit after posedge, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_result: got acc=%h ovf=%b cnt=%0d, required no result",
                 out_acc, out_ovf, out_count);
      end else begin
        e = exp_q.pop_front();
        if ({out_acc, out_ovf, out_count} !== e) begin
          errors++;
          $display("[TB] FAIL result: got acc=%h ovf=%b cnt=%0d, required acc=%h ovf=%b cnt=%0d",
                   out_acc, out_ovf, out_count, e.acc, e.ovf, e.cnt);
        end
      end
    end
  end

  function automatic void push_exp(input logic [39:0] a, input logic o, input logic [7:0] c);
    res_t r;
    r.acc = a;
    r.ovf = o;
    r.cnt = c;
    exp_q.push_back(r);
  endfunction

  task automatic send_beat(input logic [1:0] op, input logic [31:0] p, input logic last);
    bit taken;
    taken      = 1'b0;
    in_valid   = 1'b1;
    in_op      = op;
    in_product = p;
    in_last    = last;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept: in_ready stayed 0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("[TB] FAIL drain: %0d results outstanding, out_valid=%b, required 0 and 0",
               exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    checks++;
    if ({out_acc, out_ovf, out_count} !== 49'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h, required 0", {out_acc, out_ovf, out_count});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(2'b00, 32'd6, 1'b0);
    send_beat(2'b01, 32'd15, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || {out_acc, out_ovf, out_count} !== 49'd0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: valid=%b data=%h, required 0 and 0",
               out_valid, {out_acc, out_ovf, out_count});
    end
    push_exp(40'd20, 1'b0, 8'd3);
    send_beat(2'b10, 32'd1, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency: out_valid=%b one cycle after last, required 1", out_valid);
    end
    wait_drain();
  endtask

  task automatic test_sat_add();
    out_ready = 1'b1;
    send_beat(2'b00, 32'hFFFF_FFFF, 1'b0);
    push_exp(40'hFF_FFFF_FFFF, 1'b1, 8'd255);
    for (int i = 0; i < 256; i++)
      send_beat(2'b01, 32'hFFFF_FFFF, (i == 255));
    wait_drain();
  endtask

  task automatic test_sat_sub();
    out_ready = 1'b1;
    push_exp(40'd0, 1'b1, 8'd2);
    send_beat(2'b00, 32'd5, 1'b0);
    send_beat(2'b10, 32'd9, 1'b1);
    push_exp(40'd3, 1'b0, 8'd1);
    send_beat(2'b00, 32'd3, 1'b1);
    wait_drain();
  endtask

  task automatic test_clear_last();
    out_ready = 1'b1;
    push_exp(40'd0, 1'b0, 8'd0);
    send_beat(2'b00, 32'd10, 1'b0);
    send_beat(2'b01, 32'd3, 1'b0);
    send_beat(2'b11, 32'd77, 1'b1);
    push_exp(40'd2, 1'b0, 8'd1);
    send_beat(2'b01, 32'd2, 1'b1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_exp(40'd1, 1'b0, 8'd1);
    send_beat(2'b00, 32'd1, 1'b1);
    push_exp(40'd2, 1'b0, 8'd1);
    send_beat(2'b00, 32'd2, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready: got %b, required 0", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_acc !== 40'd1 || out_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL stall_stable: valid=%b acc=%h cnt=%0d, required 1 1 1",
               out_valid, out_acc, out_count);
    end
    push_exp(40'd3, 1'b0, 8'd1);
    fork
      send_beat(2'b00, 32'd3, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ready_after_pop: got %b, required 1", in_ready);
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_back_to_back();
    bit done;
    done  = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [1:0]  op;
          logic [31:0] p;
          logic        last;
          longint      s;
          op   = 2'($urandom_range(0, 3));
          p    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 50));
          last = ($urandom_range(0, 3) == 0) || (i == 59);
          case (op)
            2'b00: begin m_acc = 40'(p); m_ovf = 1'b0; m_cnt = 8'd1; end
            2'b01: begin
              s = longint'(m_acc) + longint'(p);
              if (s > 64'd1099511627775) begin m_acc = '1; m_ovf = 1'b1; end
              else m_acc = s[39:0];
              if (m_cnt != 8'd255) m_cnt++;
            end
            2'b10: begin
              if (longint'(p) > longint'(m_acc)) begin m_acc = '0; m_ovf = 1'b1; end
              else m_acc = m_acc - 40'(p);
              if (m_cnt != 8'd255) m_cnt++;
            end
            default: begin m_acc = '0; m_ovf = 1'b0; m_cnt = '0; end
          endcase
          if (last) begin
            push_exp(m_acc, m_ovf, m_cnt);
            m_acc = '0;
            m_ovf = 1'b0;
            m_cnt = '0;
          end
          send_beat(op, p, last);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_beat(2'b00, 32'd9, 1'b1);
    send_beat(2'b00, 32'd7, 1'b0);
    send_beat(2'b01, 32'd7, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || {out_acc, out_ovf, out_count} !== 49'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b ready=%b data=%h, required 0 0 0",
               out_valid, in_ready, {out_acc, out_ovf, out_count});
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_exp(40'd4, 1'b0, 8'd1);
    send_beat(2'b01, 32'd4, 1'b1);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    in_op      = 2'b00;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    $display("[TB] starting product_accumulator bench");
    test_reset();
    test_basic();
    test_sat_add();
    test_sat_sub();
    test_clear_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
